uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler and bit-timing controller for the shared UART transmit datapath (shift register, parity generator, output mux).
- Arbitrates among N_REQ byte requesters.
- Captures the winning byte and sequences the datapath with load/shift/parity_load/sel.
- Generates bit timing from the system clock, so the datapath needs no timing logic of its own.

Parameters:
N_REQ, 4, number of requesters (>=2)
CLKS_PER_BIT, 16, clk cycles per UART bit (>=1)
PARITY_EN, 1, 1 = frame includes parity bit; 0 = parity bit omitted

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  N_REQ  per-requester byte valid; held until matching req_ready
req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
tx_data  out  8  captured byte presented to datapath load input
load  out  1  one-cycle pulse: datapath loads tx_data into its shift register
shift  out  1  one-cycle pulse: datapath shifts right by one
parity_load  out  1  one-cycle pulse: datapath latches computed parity
sel  out  2  output mux: 00 start(0), 01 data LSB, 10 parity, 11 stop/idle(1)
busy  out  1  high while a frame is in progress
grant_id  out  clog2(N_REQ)  index of the requester owning the current frame

Behaviour:
- Reset (async assert, sync release): state IDLE; sel=11; load/shift/parity_load/req_ready=0; busy=0; tx_data=0; grant_id=0; bit counter=0; RR pointer set so requester 0 has top priority.
- All outputs are registered.
- States and transitions:
  - IDLE: sel=11. If any req_valid at edge E, pick the winner.
  - Arbitration: first valid requester at or after (last_grant+1) mod N_REQ.
  - On the winning edge, enter START: tx_data<=winner byte; grant_id<=winner; last_grant<=winner. In the cycle after E: req_ready[winner]=1, load=1, busy=1, sel=00.
  - START: CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bit periods, sel=01, bit index 0..7. At the last cycle of bits 0..6, shift=1. At the last cycle of bit 7: if PARITY_EN, parity_load=1 and go to PARITY; otherwise no pulse and go to STOP.
  - PARITY: sel=10 for CLKS_PER_BIT cycles, then STOP.
  - STOP: sel=11 for CLKS_PER_BIT cycles.
  - End of STOP: if any req_valid, re-arbitrate and go directly to START (no idle cycle; load/req_ready behave as from IDLE). Otherwise go to IDLE with busy=0.
- Frame length: 11*CLKS_PER_BIT clocks (10* with PARITY_EN=0), from the load cycle to the last STOP cycle inclusive.
- Pulse counts: exactly 7 shift pulses and at most 1 parity_load pulse per frame.
- Bit counter: 0..CLKS_PER_BIT-1 and wraps; bit_end = (count==CLKS_PER_BIT-1). For CLKS_PER_BIT=1, every cycle is bit_end.
- req_valid changes during a frame are ignored; only sampled at IDLE or end-of-STOP.
- A requester dropping valid before grant is simply not selected.
- req_ready is never asserted to a non-granted requester. Never more than one bit of req_ready is high.
- Reset mid-frame: immediate return to IDLE values, sel=11 (line high), frame aborted. No req_ready is issued for a byte not yet accepted.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP.
  - sel codes: SEL_START=2'b00, SEL_DATA=2'b01, SEL_PARITY=2'b10, SEL_STOP=2'b11.
  - Frame constant DATA_BITS=8.
- One sub-module, uart_rr_arbiter. It is purely combinational: inputs req_valid and last_grant; outputs any_valid and winner index.

Test Plan:
- CLKS_PER_BIT=4; only req_valid[1], data 0xA5 -> req_ready[1] and load pulse one cycle after the sampling edge; grant_id=1; sel=00 for 4 cycles, then 01 for 32, then 10 for 4, then 11 for 4; 7 shift pulses at cycles 7,11,...,31 after load; parity_load at cycle 35; busy high 44 cycles.
- All 4 req_valid held continuously -> grants in order 0,1,2,3,0; frames back-to-back with no IDLE cycle; each req_ready pulse coincides with its load.
- Requester 2 asserts valid mid-frame of requester 0 -> no effect until STOP ends; then requester 2 is granted immediately and its frame starts on the next cycle.
- Reset asserted (0) during DATA bit 3 for 2 cycles -> outputs go to reset values asynchronously, sel=11; after release with req_valid[3]=1, requester 0 has priority but 3 is granted as the only valid; a fresh full frame follows.
- PARITY_EN=0, CLKS_PER_BIT=1, single request 0xFF -> sel sequence 00, 01x8, 11; 7 shifts; parity_load never asserted; busy high 10 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b10;
  localparam logic [1:0] SEL_STOP   = 2'b11;

  localparam int unsigned DATA_BITS = 8;

  // Output mux code the datapath should see while in a given state.
  function automatic logic [1:0] sel_of(state_e s);
    case (s)
      START:   return SEL_START;
      DATA:    return SEL_DATA;
      PARITY:  return SEL_PARITY;
      default: return SEL_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last_grant.
module uart_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned GW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    last_grant,
  output logic             any_valid,
  output logic [GW-1:0]    winner
);

  // Walk the requesters starting just after the previous owner.
  always_comb begin
    logic [GW-1:0] idx;
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = GW'((32'(last_grant) + i) % N_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler and bit-timing sequencer for a shared UART TX datapath.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1,
  localparam int unsigned GW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               load,
  output logic               shift,
  output logic               parity_load,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  localparam int unsigned    CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] last_grant_q;
  logic          any_valid;
  logic [GW-1:0] winner;
  logic          bit_end;
  logic          start_frame;

  uart_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // Next state, bit-period counter and data-bit index.
  always_comb begin
    bit_end     = (cnt_q == CNT_LAST);
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + 1'b1;
    bit_d       = bit_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        start_frame = any_valid;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) state_d = PARITY_EN ? PARITY : STOP;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Back-to-back frames: re-arbitrate on the last stop cycle.
        if (bit_end) begin
          if (any_valid) start_frame = 1'b1;
          else           state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_frame) begin
      state_d = START;
      cnt_d   = '0;
      bit_d   = '0;
    end
  end

  // State plus outputs registered from next-state values, so pulses land on bit_end cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      tx_data      <= '0;
      grant_id     <= '0;
      req_ready    <= '0;
      load         <= 1'b0;
      shift        <= 1'b0;
      parity_load  <= 1'b0;
      sel          <= SEL_STOP;
      busy         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sel         <= sel_of(state_d);
      busy        <= (state_d != IDLE);
      load        <= start_frame;
      req_ready   <= start_frame ? (N_REQ'(1) << winner) : '0;
      shift       <= (state_d == DATA) && (cnt_d == CNT_LAST) && (bit_d != BIT_LAST);
      parity_load <= PARITY_EN && (state_d == DATA) && (cnt_d == CNT_LAST) &&
                     (bit_d == BIT_LAST);
      if (start_frame) begin
        tx_data      <= req_data[{winner, 3'b000} +: 8];
        grant_id     <= winner;
        last_grant_q <= winner;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: frame-level reference model plus per-cycle monitors.
module tb_uart_tx_sched;

  localparam int N      = 4;
  localparam int CPB1   = 4;
  localparam int FRAME1 = 11 * CPB1;
  localparam int CPB2   = 1;
  localparam int FRAME2 = 10 * CPB2;

  typedef struct {
    int id;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: CLKS_PER_BIT=4, parity on
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        load, shift, parity_load, busy;
  logic [1:0]  sel;
  logic [1:0]  grant_id;

  // DUT 2: CLKS_PER_BIT=1, parity off
  logic        rst2;
  logic [3:0]  v2;
  logic [31:0] d2;
  logic [3:0]  rdy2;
  logic [7:0]  txd2;
  logic        load2, shift2, par2, busy2;
  logic [1:0]  sel2;
  logic [1:0]  gid2;

  uart_tx_sched #(.N_REQ(N), .CLKS_PER_BIT(CPB1), .PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .load(load), .shift(shift),
    .parity_load(parity_load), .sel(sel), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.N_REQ(N), .CLKS_PER_BIT(CPB2), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .reset(rst2), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .tx_data(txd2), .load(load2), .shift(shift2),
    .parity_load(par2), .sel(sel2), .busy(busy2), .grant_id(gid2)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_g = N - 1;
  int   next_free = 0;
  int   hs = -1;
  int   cur_load = -1;
  bit   rearm = 0;
  int   arm_pct = 0;
  int   drop_pct = 0;
  bit   done2 = 0;
  bit   rq_valid[N];
  logic [7:0] rq_data[N];
  exp_t exp_q[$];
  exp_t exp2_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endfunction

  // Frame shape from the bit-level description: start, 8 data, [parity], stop.
  function automatic int exp_sel(input int off, input int cpb, input bit pe);
    if (off < cpb) return 0;
    if (off < 9 * cpb) return 1;
    if (pe && off < 10 * cpb) return 2;
    return 3;
  endfunction

  function automatic int exp_shift(input int off, input int cpb);
    return (off >= cpb && off < 8 * cpb && (off + 1) % cpb == 0) ? 1 : 0;
  endfunction

  function automatic int exp_par(input int off, input int cpb, input bit pe);
    return (pe && off == 9 * cpb - 1) ? 1 : 0;
  endfunction

  task automatic chk_cycle(input string t, input int cpb, input bit pe, input bit inf,
                           input int off, input logic [1:0] s, input logic b,
                           input logic sh, input logic pl);
    if (inf) begin
      chk({t, "_sel"}, s, exp_sel(off, cpb, pe));
      chk({t, "_busy"}, b, 1);
      chk({t, "_shift"}, sh, exp_shift(off, cpb));
      chk({t, "_parity_load"}, pl, exp_par(off, cpb, pe));
    end else begin
      chk({t, "_idle_sel"}, s, 3);
      chk({t, "_idle_busy"}, b, 0);
      chk({t, "_idle_shift"}, sh, 0);
      chk({t, "_idle_parity_load"}, pl, 0);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rq_valid[i];
      req_data[8*i +: 8] = rq_data[i];
    end
  endtask

  // One clock: reference model decides grants from the sampled requests, then requesters update.
  task automatic tick();
    int   w;
    int   done_hs;
    exp_t e;
    @(posedge clk);
    cyc++;
    w = -1;
    done_hs = hs;
    if (!reset) begin
      last_g = N - 1;
      next_free = 0;
      hs = -1;
      done_hs = -1;
      exp_q.delete();
    end else begin
      if (cyc >= next_free) begin
        for (int i = 1; i <= N; i++)
          if (w < 0 && rq_valid[(last_g + i) % N]) w = (last_g + i) % N;
        if (w >= 0) begin
          e.id = w;
          e.data = int'(rq_data[w]);
          e.cyc = cyc;
          exp_q.push_back(e);
          last_g = w;
          next_free = cyc + FRAME1;
          cur_load = cyc;
        end
      end
      hs = w;
    end
    #1;
    if (done_hs >= 0) begin
      rq_valid[done_hs] = 0;
      if (rearm) begin
        rq_valid[done_hs] = 1;
        rq_data[done_hs] = 8'($urandom);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i != hs) begin
        if (!rq_valid[i]) begin
          if ($urandom_range(99) < arm_pct) begin
            rq_valid[i] = 1;
            rq_data[i] = 8'($urandom);
          end
        end else if ($urandom_range(99) < drop_pct) begin
          rq_valid[i] = 0;
        end
      end
    end
    drive_bus();
  endtask

  // Monitor for DUT 1.
  int off1 = 0;
  bit in1 = 0;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset) begin
      in1 = 0;
      off1 = 0;
      chk("rst_sel", sel, 3);
      chk("rst_busy", busy, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_load", load, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_shift", shift, 0);
      chk("rst_parity_load", parity_load, 0);
    end else begin
      if (load) begin
        if (exp_q.size() == 0) begin
          chk("load_unexpected", load, 0);
        end else begin
          e = exp_q.pop_front();
          chk("load_cycle", cyc, e.cyc);
          chk("grant_id", grant_id, e.id);
          chk("tx_data", tx_data, e.data);
          chk("req_ready", req_ready, 32'(1) << e.id);
        end
        in1 = 1;
        off1 = 0;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("load_missing", load, 1);
          void'(exp_q.pop_front());
        end
        chk("req_ready_quiet", req_ready, 0);
        if (in1) begin
          off1++;
          if (off1 >= FRAME1) in1 = 0;
        end
      end
      chk_cycle("d1", CPB1, 1'b1, in1, off1, sel, busy, shift, parity_load);
    end
  end

  // Monitor for DUT 2.
  int off2 = 0;
  bit in2 = 0;
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst2) begin
      in2 = 0;
      off2 = 0;
      chk("d2_rst_sel", sel2, 3);
      chk("d2_rst_busy", busy2, 0);
    end else begin
      if (load2) begin
        if (exp2_q.size() == 0) begin
          chk("d2_load_unexpected", load2, 0);
        end else begin
          e = exp2_q.pop_front();
          chk("d2_grant_id", gid2, e.id);
          chk("d2_tx_data", txd2, e.data);
          chk("d2_req_ready", rdy2, 32'(1) << e.id);
        end
        in2 = 1;
        off2 = 0;
      end else begin
        chk("d2_req_ready_quiet", rdy2, 0);
        if (in2) begin
          off2++;
          if (off2 >= FRAME2) in2 = 0;
        end
      end
      chk_cycle("d2", CPB2, 1'b0, in2, off2, sel2, busy2, shift2, par2);
    end
  end

  // DUT 2 stimulus: two isolated single-byte frames.
  initial begin : stim2
    exp_t e;
    rst2 = 0;
    v2 = '0;
    d2 = '0;
    repeat (3) @(posedge clk);
    #3 rst2 = 1;
    #1;
    v2[0] = 1'b1;
    d2[7:0] = 8'hFF;
    e.id = 0; e.data = 8'hFF; e.cyc = -1;
    exp2_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1 v2[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    v2[2] = 1'b1;
    d2[23:16] = 8'h3C;
    e.id = 2; e.data = 8'h3C;
    exp2_q.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1 v2[2] = 1'b0;
    repeat (12) @(posedge clk);
    done2 = 1;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1);
  end

  // Main stimulus for DUT 1.
  initial begin : stim1
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq_valid[i] = 0;
      rq_data[i] = '0;
    end
    drive_bus();
    repeat (3) tick();
    #3 reset = 1'b1;

    // Single requester 1 with 0xA5.
    rq_data[1] = 8'hA5;
    rq_valid[1] = 1;
    drive_bus();
    repeat (60) tick();

    // All requesters continuously valid after a fresh reset: 0,1,2,3,0 back-to-back.
    #1 reset = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    rearm = 1;
    for (int i = 0; i < N; i++) begin
      rq_valid[i] = 1;
      rq_data[i] = 8'($urandom);
    end
    drive_bus();
    repeat (5 * FRAME1) tick();
    rearm = 0;
    for (int i = 0; i < N; i++) if (i != hs) rq_valid[i] = 0;
    drive_bus();
    repeat (50) tick();

    // Requester 2 arrives mid-frame of requester 0.
    rq_data[0] = 8'h5A;
    rq_valid[0] = 1;
    drive_bus();
    repeat (10) tick();
    rq_data[2] = 8'hC3;
    rq_valid[2] = 1;
    drive_bus();
    repeat (100) tick();

    // Reset during data bit 3, requester 3 waiting across the release.
    cur_load = -1;
    rq_data[0] = 8'h96;
    rq_valid[0] = 1;
    drive_bus();
    for (int k = 0; k < 100 && !(cur_load >= 0 && cyc == cur_load + 17); k++) tick();
    chk("bit3_sel", sel, 1);
    chk("bit3_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_sel", sel, 3);
    chk("async_busy", busy, 0);
    chk("async_tx_data", tx_data, 0);
    chk("async_grant_id", grant_id, 0);
    chk("async_shift", shift, 0);
    rq_data[3] = 8'h3C;
    rq_valid[3] = 1;
    drive_bus();
    tick();
    tick();
    #2 reset = 1'b1;
    repeat (60) tick();

    // Randomized traffic.
    arm_pct = 15;
    drop_pct = 2;
    repeat (3000) tick();

    // Drain.
    arm_pct = 0;
    drop_pct = 0;
    for (int i = 0; i < N; i++) if (i != hs) rq_valid[i] = 0;
    drive_bus();
    repeat (60) tick();
    chk("drain_expected_loads", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    for (int k = 0; k < 1000 && !done2; k++) @(posedge clk);
    chk("d2_done", 32'(done2), 1);
    chk("d2_drain_expected_loads", exp2_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
